// File: rtl/uart_rx_os.sv
// Purpose: oversampled UART receiver with parity and stop-bit checks, feeding a FWFT frame FIFO.
// Latency: a frame appears on m_valid one clk after the PUSH cycle that follows the last stop-bit sample.
// Backpressure: m_valid/m_ready on the FIFO head; a frame arriving while the FIFO is full and not popping is dropped with overrun.
//
// Ports: clk/reset (async, active high); rx serial line; baud_tick at OVERSAMPLE x baud;
//   parity_en/parity_odd/two_stop frame config (latched at start bit);
//   m_data/m_parity_err/m_frame_err/m_valid/m_ready FIFO head; overrun drop pulse;
//   fifo_count occupancy; busy = receiver active.
// Optional: define UART_RX_BREAK_DETECT_EN to add the break_det output.
module uart_rx_os #(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rx,
   input  logic                          baud_tick,
   input  logic                          parity_en,
   input  logic                          parity_odd,
   input  logic                          two_stop,
   output logic [DATA_WIDTH-1:0]         m_data,
   output logic                          m_parity_err,
   output logic                          m_frame_err,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
`ifdef UART_RX_BREAK_DETECT_EN
   output logic                          break_det,
`endif
   output logic                          busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_WIDTH + 2;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_PUSH} state_t;

   state_t                state_q;
   logic                  rx_meta_q, rx_s_q;
   logic [CW-1:0]         tick_cnt_q;
   logic [IW-1:0]         bit_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  xor_q, perr_q, ferr_q, stop2_q, armed_q;
   logic                  pen_q, podd_q, two_q;
   logic                  push_req;
`ifdef UART_RX_BREAK_DETECT_EN
   logic                  pbit_q, s1zero_q, break_q;
   logic                  brk_frame;
`endif

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   wire mid_bit  = (tick_cnt_q == CW'(OVERSAMPLE - 1));
   wire half_bit = (tick_cnt_q == CW'(OVERSAMPLE / 2 - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         tick_cnt_q <= '0;
         bit_q      <= '0;
         data_q     <= '0;
         xor_q      <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         stop2_q    <= 1'b0;
         armed_q    <= 1'b0;
         pen_q      <= 1'b0;
         podd_q     <= 1'b0;
         two_q      <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
         pbit_q     <= 1'b0;
         s1zero_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               // A start edge only counts once the line has been seen high in IDLE,
               // so a line stuck low does not retrigger frames.
               if (rx_s_q) armed_q <= 1'b1;
               if (baud_tick && !rx_s_q && armed_q) begin
                  state_q    <= S_START;
                  tick_cnt_q <= '0;
                  armed_q    <= 1'b0;
                  pen_q      <= parity_en;
                  podd_q     <= parity_odd;
                  two_q      <= two_stop;
                  xor_q      <= 1'b0;
                  perr_q     <= 1'b0;
                  ferr_q     <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                  pbit_q     <= 1'b0;
                  s1zero_q   <= 1'b0;
`endif
               end
            end
            S_START: if (baud_tick) begin
               if (half_bit) begin
                  tick_cnt_q <= '0;
                  bit_q      <= '0;
                  state_q    <= rx_s_q ? S_IDLE : S_DATA;
               end else begin
                  tick_cnt_q <= tick_cnt_q + CW'(1);
               end
            end
            S_DATA: if (baud_tick) begin
               if (mid_bit) begin
                  tick_cnt_q <= '0;
                  data_q     <= {rx_s_q, data_q[DATA_WIDTH-1:1]};
                  xor_q      <= xor_q ^ rx_s_q;
                  if (bit_q == IW'(DATA_WIDTH - 1)) begin
                     state_q <= pen_q ? S_PARITY : S_STOP;
                     stop2_q <= 1'b0;
                  end else begin
                     bit_q <= bit_q + IW'(1);
                  end
               end else begin
                  tick_cnt_q <= tick_cnt_q + CW'(1);
               end
            end
            S_PARITY: if (baud_tick) begin
               if (mid_bit) begin
                  tick_cnt_q <= '0;
                  perr_q     <= xor_q ^ rx_s_q ^ podd_q;
                  stop2_q    <= 1'b0;
                  state_q    <= S_STOP;
`ifdef UART_RX_BREAK_DETECT_EN
                  pbit_q     <= rx_s_q;
`endif
               end else begin
                  tick_cnt_q <= tick_cnt_q + CW'(1);
               end
            end
            S_STOP: if (baud_tick) begin
               if (mid_bit) begin
                  tick_cnt_q <= '0;
                  if (!rx_s_q) ferr_q <= 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                  if (!stop2_q) s1zero_q <= !rx_s_q;
`endif
                  // A bad first stop bit ends the frame without checking the second.
                  if (rx_s_q && two_q && !stop2_q) stop2_q <= 1'b1;
                  else                             state_q <= S_PUSH;
               end else begin
                  tick_cnt_q <= tick_cnt_q + CW'(1);
               end
            end
            S_PUSH:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef UART_RX_BREAK_DETECT_EN
   assign brk_frame = (data_q == '0) && (!pen_q || !pbit_q) && s1zero_q;
   assign push_req  = (state_q == S_PUSH) && !brk_frame;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                              break_q <= 1'b0;
      else if (state_q == S_PUSH && brk_frame) break_q <= 1'b1;
      else if (rx_s_q)                        break_q <= 1'b0;
   end
   assign break_det = break_q;
`else
   assign push_req = (state_q == S_PUSH);
`endif

   assign busy = (state_q != S_IDLE);

   // First-word-fall-through frame FIFO
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   fcnt_q;
   logic          full, pop, push_ok;
   logic [EW-1:0] head;

   assign full    = (fcnt_q == (AW + 1)'(FIFO_DEPTH));
   assign m_valid = (fcnt_q != '0);
   assign pop     = m_valid && m_ready;
   // Popping in the same cycle frees the slot the push needs.
   assign push_ok = push_req && (!full || pop);
   assign overrun = push_req && full && !pop;

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= {ferr_q, perr_q, data_q};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q   <= '0;
         rd_q   <= '0;
         fcnt_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + AW'(1);
         if (pop)     rd_q <= rd_q + AW'(1);
         case ({push_ok, pop})
            2'b10:   fcnt_q <= fcnt_q + (AW + 1)'(1);
            2'b01:   fcnt_q <= fcnt_q - (AW + 1)'(1);
            default: fcnt_q <= fcnt_q;
         endcase
      end
   end

   // Outputs read 0 while empty so stale storage never leaks out.
   assign head         = m_valid ? mem_q[rd_q] : '0;
   assign m_data       = head[DATA_WIDTH-1:0];
   assign m_parity_err = head[DATA_WIDTH];
   assign m_frame_err  = head[DATA_WIDTH+1];
   assign fifo_count   = fcnt_q;

endmodule
